// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath: IR field positions, ALU op encoding,
// register indices and the C-field sign-extension helper.
package datapath_pkg;

  parameter int unsigned DataWidth = 32;
  parameter int unsigned NumGprs   = 16;
  parameter int unsigned RegZero   = 0;

  parameter int unsigned RaMsb = 26;
  parameter int unsigned RaLsb = 23;
  parameter int unsigned RbMsb = 22;
  parameter int unsigned RbLsb = 19;
  parameter int unsigned RcMsb = 18;
  parameter int unsigned RcLsb = 15;
  parameter int unsigned CMsb  = 18;

  typedef enum logic [3:0] {
    AluNone,
    AluInc,
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluShr,
    AluShl,
    AluRor,
    AluRol,
    AluNeg,
    AluNot
  } alu_op_e;

  function automatic logic [DataWidth-1:0] sign_ext_c(input logic [DataWidth-1:0] ir);
    return {{(DataWidth - CMsb - 1){ir[CMsb]}}, ir[CMsb:0]};
  endfunction

endpackage

// File: rtl/datapath_if.sv
// Control strobes and memory read data presented to the datapath by the control unit.
interface datapath_if;
  logic        PCout, Zlowout, MDRout, Cout, BAout, Rout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
  logic        Gra, Grb, Grc;
  logic        IncPC, read;
  logic        ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT;
  logic [31:0] Mdatain;

  modport master (
    output PCout, Zlowout, MDRout, Cout, BAout, Rout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
    output Gra, Grb, Grc, IncPC, read,
    output ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
    output Mdatain
  );

  modport slave (
    input PCout, Zlowout, MDRout, Cout, BAout, Rout,
    input MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
    input Gra, Grb, Grc, IncPC, read,
    input ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
    input Mdatain
  );
endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU: A is the Y register, B is the bus; 32-bit result zero-extended to 64.
module datapath_alu
  import datapath_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o
);

  logic [4:0]  shamt;
  logic [5:0]  shamt_inv;
  logic [31:0] res;

  assign shamt     = b_i[4:0];
  // A shift by 32 yields zero, so a zero rotate amount needs no special case.
  assign shamt_inv = 6'd32 - {1'b0, shamt};

  always_comb begin
    res = '0;
    case (op_i)
      AluInc:  res = b_i + 32'd4;
      AluAdd:  res = a_i + b_i;
      AluSub:  res = a_i - b_i;
      AluAnd:  res = a_i & b_i;
      AluOr:   res = a_i | b_i;
      AluShr:  res = a_i >> shamt;
      AluShl:  res = a_i << shamt;
      AluRor:  res = (a_i >> shamt) | (a_i << shamt_inv);
      AluRol:  res = (a_i << shamt) | (a_i >> shamt_inv);
      AluNeg:  res = 32'd0 - b_i;
      AluNot:  res = ~b_i;
      default: res = '0;
    endcase
  end

  assign result_o = {32'd0, res};

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath with 16 GPRs, PC/IR/MAR/MDR/Y/Z and one ALU.
// Define DATAPATH_BUS_CHECK_EN for a simulation-only bus/ALU conflict check.
module datapath
  import datapath_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  datapath_if.slave   ctl,
  output logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7,
  output logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15,
  output logic [31:0] Hi, Lo, PC, IR, MAR, MDR,
  output logic [63:0] Z,
  output logic [63:0] ALUout,
  output logic [31:0] bus_mux_out,
  output logic [31:0] C_sign_ext,
  output logic [15:0] Rins,
  output logic [15:0] Routs
);

  logic [31:0] gpr_q [NumGprs];
  logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q;
  logic [63:0] z_q;
  logic [3:0]  sel;
  logic [15:0] dec;
  alu_op_e     alu_op;

  assign C_sign_ext = sign_ext_c(ir_q);

  assign sel = ({4{ctl.Gra}} & ir_q[RaMsb:RaLsb]) |
               ({4{ctl.Grb}} & ir_q[RbMsb:RbLsb]) |
               ({4{ctl.Grc}} & ir_q[RcMsb:RcLsb]);
  assign dec   = 16'd1 << sel;
  assign Rins  = ctl.Rin ? dec : '0;
  assign Routs = (ctl.Rout | ctl.BAout) ? dec : '0;

  always_comb begin
    if (|Routs) begin
      // Base-address reads treat R0 as the constant zero.
      bus_mux_out = (ctl.BAout && (sel == 4'(RegZero))) ? '0 : gpr_q[sel];
    end else if (ctl.PCout)   bus_mux_out = pc_q;
    else if (ctl.MDRout)      bus_mux_out = mdr_q;
    else if (ctl.Zlowout)     bus_mux_out = z_q[31:0];
    else if (ctl.Cout)        bus_mux_out = C_sign_ext;
    else                      bus_mux_out = '0;
  end

  always_comb begin
    if (ctl.IncPC)    alu_op = AluInc;
    else if (ctl.ADD) alu_op = AluAdd;
    else if (ctl.SUB) alu_op = AluSub;
    else if (ctl.AND) alu_op = AluAnd;
    else if (ctl.OR)  alu_op = AluOr;
    else if (ctl.SHR) alu_op = AluShr;
    else if (ctl.SHL) alu_op = AluShl;
    else if (ctl.ROR) alu_op = AluRor;
    else if (ctl.ROL) alu_op = AluRol;
    else if (ctl.NEG) alu_op = AluNeg;
    else if (ctl.NOT) alu_op = AluNot;
    else              alu_op = AluNone;
  end

  datapath_alu u_alu (
    .op_i     (alu_op),
    .a_i      (y_q),
    .b_i      (bus_mux_out),
    .result_o (ALUout)
  );

  for (genvar i = 0; i < NumGprs; i++) begin : g_gpr
    always_ff @(posedge clk or negedge clear) begin
      if (!clear)       gpr_q[i] <= '0;
      else if (Rins[i]) gpr_q[i] <= bus_mux_out;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      if (ctl.PCin)  pc_q  <= bus_mux_out;
      if (ctl.IRin)  ir_q  <= bus_mux_out;
      if (ctl.MARin) mar_q <= bus_mux_out;
      if (ctl.MDRin) mdr_q <= ctl.read ? ctl.Mdatain : bus_mux_out;
      if (ctl.Yin)   y_q   <= bus_mux_out;
      if (ctl.Zin)   z_q   <= ALUout;
    end
  end

  assign R0  = gpr_q[0];
  assign R1  = gpr_q[1];
  assign R2  = gpr_q[2];
  assign R3  = gpr_q[3];
  assign R4  = gpr_q[4];
  assign R5  = gpr_q[5];
  assign R6  = gpr_q[6];
  assign R7  = gpr_q[7];
  assign R8  = gpr_q[8];
  assign R9  = gpr_q[9];
  assign R10 = gpr_q[10];
  assign R11 = gpr_q[11];
  assign R12 = gpr_q[12];
  assign R13 = gpr_q[13];
  assign R14 = gpr_q[14];
  assign R15 = gpr_q[15];

  // No instruction in this datapath writes Hi/Lo.
  assign Hi  = '0;
  assign Lo  = '0;
  assign PC  = pc_q;
  assign IR  = ir_q;
  assign MAR = mar_q;
  assign MDR = mdr_q;
  assign Z   = z_q;

`ifdef DATAPATH_BUS_CHECK_EN
  always @(posedge clk) begin
    if (clear && $countones({ctl.Rout | ctl.BAout, ctl.PCout, ctl.MDRout,
                             ctl.Zlowout, ctl.Cout}) > 1)
      $error("datapath: more than one bus driver asserted");
    if (clear && $countones({ctl.IncPC, ctl.ADD, ctl.SUB, ctl.AND, ctl.OR, ctl.SHR,
                             ctl.SHL, ctl.ROR, ctl.ROL, ctl.NEG, ctl.NOT}) > 1)
      $error("datapath: more than one ALU op asserted");
  end
`endif

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: spec-level model checked every cycle plus literal expectations.
module tb_datapath;
  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  datapath_if ctl();

  logic [31:0] r_out [16];
  logic [31:0] hi, lo, pc, ir, mar, mdr, bus, csx;
  logic [63:0] z, alu_out;
  logic [15:0] rins, routs;

  datapath dut (
    .clk(clk), .clear(clear), .ctl(ctl),
    .R0(r_out[0]), .R1(r_out[1]), .R2(r_out[2]), .R3(r_out[3]),
    .R4(r_out[4]), .R5(r_out[5]), .R6(r_out[6]), .R7(r_out[7]),
    .R8(r_out[8]), .R9(r_out[9]), .R10(r_out[10]), .R11(r_out[11]),
    .R12(r_out[12]), .R13(r_out[13]), .R14(r_out[14]), .R15(r_out[15]),
    .Hi(hi), .Lo(lo), .PC(pc), .IR(ir), .MAR(mar), .MDR(mdr),
    .Z(z), .ALUout(alu_out), .bus_mux_out(bus), .C_sign_ext(csx),
    .Rins(rins), .Routs(routs)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y;
  logic [63:0] m_z;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0; m_z = '0;
  endtask

  function automatic int m_sel();
    int s = 0;
    if (ctl.Gra) s = s | int'(m_ir[26:23]);
    if (ctl.Grb) s = s | int'(m_ir[22:19]);
    if (ctl.Grc) s = s | int'(m_ir[18:15]);
    return s;
  endfunction

  function automatic logic [31:0] m_csx();
    logic signed [18:0] c;
    logic signed [31:0] w;
    c = m_ir[18:0];
    w = c;
    return w;
  endfunction

  function automatic logic [31:0] m_bus();
    if (ctl.Rout || ctl.BAout) begin
      if (ctl.BAout && m_sel() == 0) return 32'd0;
      return m_r[m_sel()];
    end
    if (ctl.PCout)   return m_pc;
    if (ctl.MDRout)  return m_mdr;
    if (ctl.Zlowout) return m_z[31:0];
    if (ctl.Cout)    return m_csx();
    return 32'd0;
  endfunction

  function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] aa;
    int n;
    n = int'(b[4:0]);
    if (ctl.IncPC) return {32'd0, b + 32'd4};
    if (ctl.ADD)   return {32'd0, a + b};
    if (ctl.SUB)   return {32'd0, a - b};
    if (ctl.AND)   return {32'd0, a & b};
    if (ctl.OR)    return {32'd0, a | b};
    if (ctl.SHR)   return {32'd0, a >> n};
    if (ctl.SHL)   return {32'd0, a << n};
    if (ctl.ROR) begin aa = {a, a} >> n; return {32'd0, aa[31:0]}; end
    if (ctl.ROL) begin aa = {a, a} << n; return {32'd0, aa[63:32]}; end
    if (ctl.NEG)   return {32'd0, ~b + 32'd1};
    if (ctl.NOT)   return {32'd0, ~b};
    return 64'd0;
  endfunction

  always @(negedge clear) m_reset();

  always @(posedge clk) begin : model_upd
    logic [31:0] b;
    logic [63:0] r;
    int s;
    if (clear) begin
      b = m_bus();
      r = m_alu(m_y, b);
      s = m_sel();
      if (ctl.Rin)   m_r[s] = b;
      if (ctl.PCin)  m_pc   = b;
      if (ctl.IRin)  m_ir   = b;
      if (ctl.MARin) m_mar  = b;
      if (ctl.MDRin) m_mdr  = ctl.read ? ctl.Mdatain : b;
      if (ctl.Yin)   m_y    = b;
      if (ctl.Zin)   m_z    = r;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), 64'(r_out[i]), 64'(m_r[i]));
      chk("Hi", 64'(hi), 64'd0);
      chk("Lo", 64'(lo), 64'd0);
      chk("PC", 64'(pc), 64'(m_pc));
      chk("IR", 64'(ir), 64'(m_ir));
      chk("MAR", 64'(mar), 64'(m_mar));
      chk("MDR", 64'(mdr), 64'(m_mdr));
      chk("Z", z, m_z);
      chk("bus", 64'(bus), 64'(m_bus()));
      chk("ALUout", alu_out, m_alu(m_y, m_bus()));
      chk("C_sign_ext", 64'(csx), 64'(m_csx()));
      chk("Rins", 64'(rins), ctl.Rin ? (64'd1 << m_sel()) : 64'd0);
      chk("Routs", 64'(routs), (ctl.Rout || ctl.BAout) ? (64'd1 << m_sel()) : 64'd0);
    end
  end

  task automatic idle();
    ctl.PCout = 0; ctl.Zlowout = 0; ctl.MDRout = 0; ctl.Cout = 0; ctl.BAout = 0;
    ctl.Rout = 0; ctl.MARin = 0; ctl.Zin = 0; ctl.PCin = 0; ctl.MDRin = 0;
    ctl.IRin = 0; ctl.Yin = 0; ctl.Rin = 0; ctl.Gra = 0; ctl.Grb = 0; ctl.Grc = 0;
    ctl.IncPC = 0; ctl.read = 0; ctl.ADD = 0; ctl.SUB = 0; ctl.AND = 0; ctl.OR = 0;
    ctl.SHR = 0; ctl.SHL = 0; ctl.ROR = 0; ctl.ROL = 0; ctl.NEG = 0; ctl.NOT = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    ctl.Mdatain = v; ctl.read = 1; ctl.MDRin = 1;
    cyc();
  endtask

  initial begin
    m_reset();
    idle();
    ctl.Mdatain = '0;
    #2 clear = 1'b0;
    @(posedge clk);
    #1 clear = 1'b1;
    check_en = 1'b1;
    chk("reset_PC", 64'(pc), 64'd0);
    chk("reset_Z", z, 64'd0);

    // Mid-run clear overrides a pending PC load and holds afterwards.
    load_mdr(32'h0000_1234);
    ctl.MDRout = 1; ctl.PCin = 1; cyc();
    chk("pc_load", 64'(pc), 64'h1234);
    ctl.MDRout = 1; ctl.PCin = 1;
    clear = 1'b0;
    #1;
    chk("clear_async_PC", 64'(pc), 64'd0);
    chk("clear_async_MDR", 64'(mdr), 64'd0);
    cyc();
    chk("clear_hold_PC", 64'(pc), 64'd0);
    clear = 1'b1;
    cyc();
    chk("clear_release_PC", 64'(pc), 64'd0);

    // PC increment sequence.
    load_mdr(32'd0);
    ctl.MDRout = 1; ctl.PCin = 1; cyc();
    ctl.PCout = 1; ctl.IncPC = 1; ctl.Zin = 1; cyc();
    chk("incpc_Z", z, 64'd4);
    ctl.Zlowout = 1; ctl.PCin = 1; cyc();
    chk("incpc_PC", 64'(pc), 64'd4);

    // R0 holds a value, but BAout selecting R0 must still drive zero.
    load_mdr(32'h55);
    ctl.MDRout = 1; ctl.Rin = 1; cyc();
    chk("r0_load", 64'(r_out[0]), 64'h55);
    ctl.Rout = 1; #1;
    chk("rout_r0_bus", 64'(bus), 64'h55);
    cyc();

    load_mdr(32'h0100_0085);
    ctl.MDRout = 1; ctl.IRin = 1; cyc();
    chk("csx_pos", 64'(csx), 64'h85);
    ctl.Grb = 1; ctl.BAout = 1; ctl.Yin = 1; #1;
    chk("baout_r0_bus", 64'(bus), 64'd0);
    cyc();
    ctl.Cout = 1; ctl.ADD = 1; ctl.Zin = 1; cyc();
    chk("add_c_Z", z, 64'h85);
    ctl.Zlowout = 1; ctl.MARin = 1; cyc();
    chk("mar_85", 64'(mar), 64'h85);

    // Load R2 through the Ra field (Ra=2).
    load_mdr(32'd2);
    ctl.MDRout = 1; ctl.Gra = 1; ctl.Rin = 1; #1;
    chk("rins_r2", 64'(rins), 64'h0004);
    cyc();
    chk("r2_load", 64'(r_out[2]), 64'd2);

    // Negative C field; BAout on a non-zero register drives its value.
    load_mdr(32'h0104_0000);
    ctl.MDRout = 1; ctl.IRin = 1; cyc();
    chk("csx_neg", 64'(csx), 64'hFFFC_0000);
    ctl.Gra = 1; ctl.BAout = 1; #1;
    chk("baout_r2_bus", 64'(bus), 64'd2);
    cyc();

    load_mdr(32'd8);
    ctl.MDRout = 1; ctl.Yin = 1; cyc();
    load_mdr(32'd3);
    ctl.MDRout = 1; ctl.SUB = 1; ctl.Zin = 1; cyc();
    chk("sub_Z", z, 64'd5);
    ctl.MDRout = 1; ctl.SHL = 1; ctl.Zin = 1; cyc();
    chk("shl_Z", z, 64'h40);
    ctl.MDRout = 1; ctl.ROR = 1; ctl.Zin = 1; cyc();
    chk("ror_Z", z, 64'd1);

    load_mdr(32'h8000_0001);
    ctl.MDRout = 1; ctl.Yin = 1; cyc();
    load_mdr(32'd1);
    ctl.MDRout = 1; ctl.ROL = 1; ctl.Zin = 1; cyc();
    chk("rol_Z", z, 64'd3);
    ctl.MDRout = 1; ctl.SHR = 1; ctl.Zin = 1; cyc();
    chk("shr_Z", z, 64'h4000_0000);
    ctl.MDRout = 1; ctl.NEG = 1; ctl.Zin = 1; cyc();
    chk("neg_Z", z, 64'h0000_0000_FFFF_FFFF);
    ctl.MDRout = 1; ctl.NOT = 1; ctl.Zin = 1; cyc();
    chk("not_Z", z, 64'h0000_0000_FFFF_FFFE);

    // Priority resolution when several sources or ops are asserted.
    ctl.PCout = 1; ctl.MDRout = 1; ctl.Zlowout = 1; ctl.MARin = 1; cyc();
    chk("bus_prio_MAR", 64'(mar), 64'd4);
    ctl.MDRout = 1; ctl.ADD = 1; ctl.SUB = 1; ctl.Zin = 1; cyc();
    chk("alu_prio_Z", z, 64'h8000_0002);
    ctl.PCout = 1; ctl.IncPC = 1; ctl.ADD = 1; ctl.Zin = 1; cyc();
    chk("incpc_prio_Z", z, 64'd8);

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
